piso_serializer: RTL and testbench

Parallel-in, serial-out serializer: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock with a framing strobe. It is the transmit-side counterpart to the library's storage flip-flops and shift registers, and feeds serial links or a downstream SIPO deserializer. It supports back-to-back frames with no idle gap, plus a synchronous abort.

---
 rtl/piso_serializer.sv | 85 ++++++++
 tb/tb_piso_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready load, framing strobe and
// synchronous abort. Back-to-back frames are accepted in the last-bit cycle.
//
// state | meaning
// IDLE  | no frame on sout; ready for a word
// SHIFT | frame bits on sout; cnt counts bits still to follow the current one
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             fire;

  assign load_ready = ~abort & ((state == IDLE) | ((state == SHIFT) & (cnt == '0)));
  assign fire       = load_valid & load_ready;
  assign busy       = sout_valid;

  // shreg holds only the bits not yet presented; the current bit lives in sout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (fire) begin
      state       <= SHIFT;
      cnt         <= CW'(WIDTH - 1);
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
      if (MSB_FIRST) begin
        sout  <= din[WIDTH-1];
        shreg <= {din[WIDTH-2:0], 1'b0};
      end else begin
        sout  <= din[0];
        shreg <= {1'b0, din[WIDTH-1:1]};
      end
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        cnt         <= cnt - CW'(1);
        frame_start <= 1'b0;
        if (MSB_FIRST) begin
          sout  <= shreg[WIDTH-1];
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          sout  <= shreg[0];
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
      end else begin
        state       <= IDLE;
        shreg       <= '0;
        sout        <= 1'b0;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against bit-queue reference models.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       load_valid = 1'b0;
  logic       abort = 1'b0;

  logic ready_m, sout_m, sv_m, fs_m, busy_m;
  logic ready_l, sout_l, sv_l, fs_l, busy_l;

  int checks = 0;
  int errors = 0;

  bit qm[$];
  bit ql[$];
  bit first_m, first_l;
  logic [15:0] cap_m, cap_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(ready_m), .abort(abort), .sout(sout_m),
    .sout_valid(sv_m), .frame_start(fs_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(ready_l), .abort(abort), .sout(sout_l),
    .sout_valid(sv_l), .frame_start(fs_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (qm.size() > 0);
    check("msb_sout_valid", 32'(sv_m), 32'(v));
    check("msb_sout", 32'(sout_m), 32'(v ? qm[0] : 1'b0));
    check("msb_frame_start", 32'(fs_m), 32'(v & first_m));
    check("msb_busy", 32'(busy_m), 32'(v));
    v = (ql.size() > 0);
    check("lsb_sout_valid", 32'(sv_l), 32'(v));
    check("lsb_sout", 32'(sout_l), 32'(v ? ql[0] : 1'b0));
    check("lsb_frame_start", 32'(fs_l), 32'(v & first_l));
    check("lsb_busy", 32'(busy_l), 32'(v));
    if (sv_m === 1'b1) cap_m = {cap_m[14:0], sout_m};
    if (sv_l === 1'b1) cap_l = {cap_l[14:0], sout_l};
  endtask

  task automatic clear_models();
    qm.delete();
    ql.delete();
    first_m = 1'b0;
    first_l = 1'b0;
  endtask

  // One clock: drive inputs, check at the falling edge, advance the models at the rising edge.
  task automatic step(input bit lv, input logic [7:0] d, input bit ab);
    bit exp_ready, fire;
    load_valid = lv;
    din        = d;
    abort      = ab;
    @(negedge clk);
    check_outputs();
    exp_ready = !ab && (qm.size() <= 1);
    check("msb_load_ready", 32'(ready_m), 32'(exp_ready));
    check("lsb_load_ready", 32'(ready_l), 32'(exp_ready));
    fire = lv && exp_ready;
    @(posedge clk);
    if (ab) begin
      clear_models();
    end else if (fire) begin
      qm.delete();
      ql.delete();
      for (int k = 0; k < 8; k++) begin
        qm.push_back(d[7-k]);
        ql.push_back(d[k]);
      end
      first_m = 1'b1;
      first_l = 1'b1;
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      first_m = 1'b0;
      first_l = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    clear_models();
    cap_m = '0;
    cap_l = '0;
    #12;
    check("reset_sout_valid", 32'(sv_m | sv_l), 32'd0);
    check("reset_sout", 32'(sout_m | sout_l), 32'd0);
    check("reset_frame_start", 32'(fs_m | fs_l), 32'd0);
    check("reset_ready", 32'({ready_m, ready_l}), 32'b11);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // idle hold after reset
    idle(20);

    // single frame 0xA5
    cap_m = '0; cap_l = '0;
    step(1'b1, 8'hA5, 1'b0);
    idle(10);
    check("a5_msb_bits", 32'(cap_m), 32'h00A5);
    check("a5_lsb_bits", 32'(cap_l), 32'h00A5);

    // back-to-back 0xA5 then 0x3C with load_valid held
    cap_m = '0;
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    idle(9);
    check("b2b_msb_bits", 32'(cap_m), 32'hA53C);

    // bit order with 0x01
    cap_m = '0; cap_l = '0;
    step(1'b1, 8'h01, 1'b0);
    idle(9);
    check("x01_msb_bits", 32'(cap_m), 32'h0001);
    check("x01_lsb_bits", 32'(cap_l), 32'h0080);

    // abort at bit 3 of 0xFF while load_valid is high
    step(1'b1, 8'hFF, 1'b0);
    idle(3);
    step(1'b1, 8'hAA, 1'b1);
    idle(2);
    cap_m = '0;
    step(1'b1, 8'h0F, 1'b0);
    idle(9);
    check("abort_then_0f", 32'(cap_m), 32'h000F);

    // async reset during bit 4 of 0xC3
    step(1'b1, 8'hC3, 1'b0);
    idle(4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'({sv_m, sout_m, fs_m, busy_m, sv_l, sout_l, fs_l, busy_l}), 32'd0);
    check("arst_ready", 32'({ready_m, ready_l}), 32'b11);
    clear_models();
    #1 rst_n = 1'b1;
    idle(3);
    cap_m = '0;
    step(1'b1, 8'h81, 1'b0);
    idle(9);
    check("post_reset_81", 32'(cap_m), 32'h0081);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
